// File: rtl/scheduler_pkg.sv
// Shared core control-state definitions for the scheduler, fetcher, decoder and LSUs.
package scheduler_pkg;

  localparam int unsigned CORE_STATE_BITS = 3;

  typedef enum logic [CORE_STATE_BITS-1:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    REQUEST = 3'd3,
    WAIT    = 3'd4,
    EXECUTE = 3'd5,
    UPDATE  = 3'd6,
    DONE    = 3'd7
  } core_state_t;

endpackage

// File: rtl/pc_min_select.sv
// Picks the smallest PC among valid lanes and flags every valid lane sitting at that PC.
module pc_min_select #(
  parameter int unsigned THREADS_PER_CORE = 4,
  parameter int unsigned PC_BITS          = 8
) (
  input  logic [THREADS_PER_CORE*PC_BITS-1:0] pc,
  input  logic [THREADS_PER_CORE-1:0]         valid,
  output logic [PC_BITS-1:0]                  min_pc,
  output logic [THREADS_PER_CORE-1:0]         match,
  output logic                                any_valid
);

  // Linear scan for the unsigned minimum over valid lanes.
  always_comb begin
    min_pc    = '1;
    any_valid = 1'b0;
    for (int i = 0; i < int'(THREADS_PER_CORE); i++) begin
      if (valid[i] && (!any_valid || (pc[i*PC_BITS +: PC_BITS] < min_pc))) begin
        min_pc    = pc[i*PC_BITS +: PC_BITS];
        any_valid = 1'b1;
      end
    end
  end

  // Lanes that reconverge on the selected PC.
  always_comb begin
    match = '0;
    for (int i = 0; i < int'(THREADS_PER_CORE); i++) begin
      match[i] = valid[i] && (pc[i*PC_BITS +: PC_BITS] == min_pc);
    end
  end

endmodule

// File: rtl/thread_scheduler.sv
// Per-core sequencer: one PC per lane, min-PC issue with reconvergence of divergent lanes.
module thread_scheduler
  import scheduler_pkg::*;
#(
  parameter int unsigned THREADS_PER_CORE = 4,
  parameter int unsigned PC_BITS          = 8,
  parameter int unsigned CNT_BITS         = $clog2(THREADS_PER_CORE) + 1
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                start,
  input  logic [CNT_BITS-1:0]                 thread_count,
  input  logic                                fetch_done,
  input  logic                                decoded_ret,
  input  logic [THREADS_PER_CORE-1:0]         lsu_busy,
  input  logic [THREADS_PER_CORE*PC_BITS-1:0] next_pc,
  output logic [PC_BITS-1:0]                  current_pc,
  output logic [THREADS_PER_CORE-1:0]         active_mask,
  output core_state_t                         core_state,
  output logic                                done
);

  logic [THREADS_PER_CORE-1:0][PC_BITS-1:0] thread_pc;
  logic [THREADS_PER_CORE-1:0][PC_BITS-1:0] upd_pc;
  logic [THREADS_PER_CORE-1:0]              retired;
  logic [THREADS_PER_CORE-1:0]              upd_retired;
  logic [THREADS_PER_CORE-1:0]              pending;
  logic [THREADS_PER_CORE-1:0]              start_mask;
  logic [THREADS_PER_CORE-1:0]              sel_match;
  logic [PC_BITS-1:0]                       sel_min;
  logic                                     sel_any;
  logic [CNT_BITS-1:0]                      count_clamped;

  // Enabled-lane mask from the requested count, clamped to the lane count.
  always_comb begin
    count_clamped = thread_count;
    if (thread_count > CNT_BITS'(THREADS_PER_CORE)) begin
      count_clamped = CNT_BITS'(THREADS_PER_CORE);
    end
    start_mask = '0;
    for (int i = 0; i < int'(THREADS_PER_CORE); i++) begin
      start_mask[i] = (CNT_BITS'(i) < count_clamped);
    end
  end

  // Post-UPDATE lane state: active lanes advance, or retire on RET.
  always_comb begin
    upd_pc      = thread_pc;
    upd_retired = retired;
    for (int i = 0; i < int'(THREADS_PER_CORE); i++) begin
      if (active_mask[i]) begin
        if (decoded_ret) begin
          upd_retired[i] = 1'b1;
        end else begin
          upd_pc[i] = next_pc[i*PC_BITS +: PC_BITS];
        end
      end
    end
    pending = ~upd_retired;
  end

  pc_min_select #(
    .THREADS_PER_CORE (THREADS_PER_CORE),
    .PC_BITS          (PC_BITS)
  ) u_min_select (
    .pc        (upd_pc),
    .valid     (pending),
    .min_pc    (sel_min),
    .match     (sel_match),
    .any_valid (sel_any)
  );

  // Control FSM with registered outputs and per-lane PC/retire state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_state  <= IDLE;
      current_pc  <= '0;
      active_mask <= '0;
      done        <= 1'b0;
      thread_pc   <= '0;
      retired     <= '1;
    end else begin
      case (core_state)
        IDLE: begin
          if (start) begin
            thread_pc  <= '0;
            current_pc <= '0;
            if (count_clamped == '0) begin
              retired     <= '1;
              active_mask <= '0;
              done        <= 1'b1;
              core_state  <= DONE;
            end else begin
              retired     <= ~start_mask;
              active_mask <= start_mask;
              core_state  <= FETCH;
            end
          end
        end
        FETCH: begin
          if (fetch_done) begin
            core_state <= DECODE;
          end
        end
        DECODE: begin
          core_state <= REQUEST;
        end
        REQUEST: begin
          core_state <= WAIT;
        end
        WAIT: begin
          // Busy requests on lanes not executing this instruction cannot stall it.
          if ((lsu_busy & active_mask) == '0) begin
            core_state <= EXECUTE;
          end
        end
        EXECUTE: begin
          core_state <= UPDATE;
        end
        UPDATE: begin
          thread_pc <= upd_pc;
          retired   <= upd_retired;
          if (!sel_any) begin
            active_mask <= '0;
            done        <= 1'b1;
            core_state  <= DONE;
          end else begin
            current_pc  <= sel_min;
            active_mask <= sel_match;
            core_state  <= FETCH;
          end
        end
        DONE: begin
          // Hold completion until the launcher drops start.
          if (!start) begin
            done       <= 1'b0;
            core_state <= IDLE;
          end
        end
        default: begin
          core_state <= IDLE;
        end
      endcase
    end
  end

endmodule
